// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
package cpu_pkg;

    typedef logic [15:0] halfword_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_FULL
    } fetch_state_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Halfword FIFO: up to two pushes and one pop per cycle, synchronous flush.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [1:0]                   push_cnt,
    input  halfword_t                    push_data0,
    input  halfword_t                    push_data1,
    input  logic                         pop,
    output halfword_t                    head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   free
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    halfword_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     wr_ptr1;
    logic [PW-1:0]     wr_ptr2;
    logic [CW-1:0]     count;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        else
            return p + PW'(1);
    endfunction

    assign wr_ptr1 = wrap_inc(wr_ptr);
    assign wr_ptr2 = wrap_inc(wr_ptr1);

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push_cnt != 2'd0)
                mem[wr_ptr] <= push_data0;
            if (push_cnt == 2'd2)
                mem[wr_ptr1] <= push_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_cnt == 2'd2)
                wr_ptr <= wr_ptr2;
            else if (push_cnt == 2'd1)
                wr_ptr <= wr_ptr1;
            if (pop)
                rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(push_cnt) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign free  = CW'(DEPTH) - count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads 32-bit words, splits them into Thumb halfwords
// and presents one halfword per cycle with its PC to decode.
//
//   state   | meaning
//   S_RESET | one idle cycle after reset or a branch redirect, req low
//   S_FETCH | request outstanding at o_imem_addr, held until acked
//   S_FULL  | fewer than two free entries, req low until space frees
module fetch_unit
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEFAULT,
    parameter int    BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_branch,
    input  logic [31:0] i_branch_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [15:0] o_ir,
    output logic        o_ir_valid,
    output logic [31:0] o_pc
);

    localparam int FW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_d;
    word_t         addr_q;
    word_t         pc_q;
    logic          skip_lo;

    logic          accept;
    logic          pop;
    logic [1:0]    push_cnt;
    halfword_t     push_data0;
    halfword_t     push_data1;
    halfword_t     head;
    logic          empty;
    logic [FW-1:0] free;
    logic [FW:0]   free_after;

    assign accept     = (state == S_FETCH) && i_imem_ack && !i_branch;
    assign pop        = !empty && !i_stall && !i_branch;
    assign push_cnt   = accept ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
    assign push_data0 = skip_lo ? i_imem_rdata[31:16] : i_imem_rdata[15:0];
    assign push_data1 = i_imem_rdata[31:16];

    // Free entries once this cycle's push and pop have both landed.
    assign free_after = {1'b0, free} + {{FW{1'b0}}, pop} - {{(FW-1){1'b0}}, push_cnt};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (i_branch),
        .push_cnt   (push_cnt),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .free       (free)
    );

    always_ff @(posedge clk) begin
        if (rst || i_branch)
            state <= S_RESET;
        else
            state <= state_d;
    end

    always_comb begin
        state_d    = state;
        o_imem_req = 1'b0;
        unique case (state)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack && free_after < (FW+1)'(2))
                    state_d = S_FULL;
            end
            S_FULL: begin
                if (free >= FW'(2))
                    state_d = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= RESET_PC & ~32'h3;
            pc_q    <= RESET_PC;
            skip_lo <= RESET_PC[1];
        end else if (i_branch) begin
            addr_q  <= i_branch_target & ~32'h3;
            pc_q    <= i_branch_target & ~32'h1;
            skip_lo <= i_branch_target[1];
        end else begin
            if (accept) begin
                addr_q  <= addr_q + 32'd4;
                skip_lo <= 1'b0;
            end
            if (pop)
                pc_q <= pc_q + 32'd2;
        end
    end

    assign o_imem_addr = addr_q;
    assign o_pc        = pc_q;
    assign o_ir_valid  = !empty;
    assign o_ir        = empty ? 16'h0000 : head;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        i_stall;
    logic        i_branch;
    logic [31:0] i_branch_target;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [15:0] o_ir;
    logic        o_ir_valid;
    logic [31:0] o_pc;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [256];
    int          wait_cycles = 0;
    logic        ack_en = 1'b1;
    int          wcnt = 0;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (i_stall),
        .i_branch        (i_branch),
        .i_branch_target (i_branch_target),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ack      (i_imem_ack),
        .i_imem_rdata    (i_imem_rdata),
        .o_ir            (o_ir),
        .o_ir_valid      (o_ir_valid),
        .o_pc            (o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks after wait_cycles cycles of continuous request.
    always @(posedge clk) begin
        if (!o_imem_req || i_imem_ack)
            wcnt <= 0;
        else
            wcnt <= wcnt + 1;
    end
    assign i_imem_ack   = o_imem_req && ack_en && (wcnt >= wait_cycles);
    assign i_imem_rdata = mem[o_imem_addr[9:2]];

    function automatic logic [15:0] exp_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1; i_stall = 1'b0; i_branch = 1'b0; ack_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_stall = 1'b0; i_branch = 1'b0; ack_en = 1'b1; wait_cycles = 0;
        repeat (2) @(negedge clk);
        checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", o_imem_req); end
        checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", o_imem_addr); end
        checks++; if (o_ir !== 16'h0) begin errors++; $display("FAIL reset_ir: got %h expected 0", o_ir); end
        checks++; if (o_ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_ir_valid); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", o_imem_req, o_imem_addr); end
        checks++; if (o_ir_valid !== 1'b0) begin errors++; $display("FAIL reset_no_early_valid: got %b expected 0", o_ir_valid); end
        for (int k = 0; k < 4; k++) begin
            logic [15:0] e_ir;
            logic [15:0] tbl [4];
            tbl[0] = 16'hAAAA; tbl[1] = 16'hBBBB; tbl[2] = 16'hCCCC; tbl[3] = 16'hDDDD;
            e_ir = tbl[k];
            @(negedge clk);
            checks++; if (o_ir_valid !== 1'b1 || o_ir !== e_ir || o_pc !== 32'(2 * k)) begin errors++; $display("FAIL reset_fetch_%0d: got v=%b ir=%h pc=%h expected v=1 ir=%h pc=%h", k, o_ir_valid, o_ir, o_pc, e_ir, 32'(2 * k)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) @(negedge clk);
        checks++; if (o_ir !== 16'hBBBB || o_pc !== 32'h2) begin errors++; $display("FAIL stall_pre: got ir=%h pc=%h expected ir=bbbb pc=2", o_ir, o_pc); end
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (o_ir_valid !== 1'b1 || o_ir !== 16'hBBBB || o_pc !== 32'h2) begin errors++; $display("FAIL stall_hold_%0d: got v=%b ir=%h pc=%h expected v=1 ir=bbbb pc=2", k, o_ir_valid, o_ir, o_pc); end
            checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL stall_full_req_%0d: got %b expected 0", k, o_imem_req); end
        end
        i_stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] e_pc;
            e_pc = 32'(4 + 2 * k);
            @(negedge clk);
            checks++; if (o_ir_valid !== 1'b1 || o_pc !== e_pc || o_ir !== exp_hw(e_pc)) begin errors++; $display("FAIL stall_resume_%0d: got v=%b ir=%h pc=%h expected v=1 ir=%h pc=%h", k, o_ir_valid, o_ir, o_pc, exp_hw(e_pc), e_pc); end
        end
    endtask

    task automatic test_unaligned_branch();
        do_reset();
        repeat (2) @(negedge clk);
        i_branch = 1'b1; i_branch_target = 32'h0000_0102;
        @(negedge clk);
        i_branch = 1'b0;
        checks++; if (o_ir_valid !== 1'b0 || o_imem_req !== 1'b0) begin errors++; $display("FAIL br_bubble1: got v=%b req=%b expected v=0 req=0", o_ir_valid, o_imem_req); end
        @(negedge clk);
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin errors++; $display("FAIL br_req: got req=%b addr=%h expected req=1 addr=100", o_imem_req, o_imem_addr); end
        checks++; if (o_ir_valid !== 1'b0) begin errors++; $display("FAIL br_bubble2: got %b expected 0", o_ir_valid); end
        @(negedge clk);
        checks++; if (o_ir_valid !== 1'b1 || o_ir !== 16'h2222 || o_pc !== 32'h102) begin errors++; $display("FAIL br_first: got v=%b ir=%h pc=%h expected v=1 ir=2222 pc=102", o_ir_valid, o_ir, o_pc); end
        @(negedge clk);
        checks++; if (o_ir_valid !== 1'b1 || o_ir !== 16'h8104 || o_pc !== 32'h104) begin errors++; $display("FAIL br_second: got v=%b ir=%h pc=%h expected v=1 ir=8104 pc=104", o_ir_valid, o_ir, o_pc); end
        // Odd target: bit 0 is discarded.
        i_branch = 1'b1; i_branch_target = 32'h0000_0107;
        @(negedge clk);
        i_branch = 1'b0;
        checks++; if (o_ir_valid !== 1'b0) begin errors++; $display("FAIL odd_bubble: got %b expected 0", o_ir_valid); end
        @(negedge clk);
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h104) begin errors++; $display("FAIL odd_req: got req=%b addr=%h expected req=1 addr=104", o_imem_req, o_imem_addr); end
        @(negedge clk);
        checks++; if (o_ir_valid !== 1'b1 || o_ir !== 16'h8106 || o_pc !== 32'h106) begin errors++; $display("FAIL odd_first: got v=%b ir=%h pc=%h expected v=1 ir=8106 pc=106", o_ir_valid, o_ir, o_pc); end
    endtask

    task automatic test_branch_race();
        do_reset();
        @(negedge clk);
        checks++; if (i_imem_ack !== 1'b1) begin errors++; $display("FAIL race_setup_ack: got %b expected 1", i_imem_ack); end
        i_branch = 1'b1; i_branch_target = 32'h0000_0040;
        @(negedge clk);
        i_branch = 1'b0;
        checks++; if (o_ir_valid !== 1'b0) begin errors++; $display("FAIL race_drop: got v=%b ir=%h expected v=0", o_ir_valid, o_ir); end
        @(negedge clk);
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h40 || o_ir_valid !== 1'b0) begin errors++; $display("FAIL race_req: got req=%b addr=%h v=%b expected req=1 addr=40 v=0", o_imem_req, o_imem_addr, o_ir_valid); end
        @(negedge clk);
        checks++; if (o_ir_valid !== 1'b1 || o_ir !== 16'h8040 || o_pc !== 32'h40) begin errors++; $display("FAIL race_first: got v=%b ir=%h pc=%h expected v=1 ir=8040 pc=40", o_ir_valid, o_ir, o_pc); end
    endtask

    task automatic test_branch_full();
        do_reset();
        repeat (3) @(negedge clk);
        i_stall = 1'b1;
        @(negedge clk);
        checks++; if (o_imem_req !== 1'b0 || o_pc !== 32'h2) begin errors++; $display("FAIL bfull_setup: got req=%b pc=%h expected req=0 pc=2", o_imem_req, o_pc); end
        i_branch = 1'b1; i_branch_target = 32'h0000_0080;
        @(negedge clk);
        i_branch = 1'b0; i_stall = 1'b0;
        checks++; if (o_ir_valid !== 1'b0) begin errors++; $display("FAIL bfull_flush: got %b expected 0", o_ir_valid); end
        @(negedge clk);
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h80) begin errors++; $display("FAIL bfull_req: got req=%b addr=%h expected req=1 addr=80", o_imem_req, o_imem_addr); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (o_ir_valid !== 1'b1 || o_pc !== 32'(32'h80 + 2 * k) || o_ir !== exp_hw(32'(32'h80 + 2 * k))) begin errors++; $display("FAIL bfull_fetch_%0d: got v=%b ir=%h pc=%h expected v=1 pc=%h", k, o_ir_valid, o_ir, o_pc, 32'(32'h80 + 2 * k)); end
        end
    endtask

    task automatic test_wait_state();
        logic [31:0] e_pc;
        logic [31:0] prev_addr;
        logic        prev_pending;
        int          got;
        logic        bubble;
        wait_cycles = 3;
        do_reset();
        e_pc = 32'h0; got = 0; bubble = 1'b0; prev_pending = 1'b0; prev_addr = 32'h0;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            @(negedge clk);
            if (prev_pending) begin
                checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== prev_addr) begin errors++; $display("FAIL wait_hold: got req=%b addr=%h expected req=1 addr=%h", o_imem_req, o_imem_addr, prev_addr); end
            end
            if (o_ir_valid) begin
                checks++; if (o_pc !== e_pc || o_ir !== exp_hw(e_pc)) begin errors++; $display("FAIL wait_order: got ir=%h pc=%h expected ir=%h pc=%h", o_ir, o_pc, exp_hw(e_pc), e_pc); end
                e_pc = e_pc + 32'd2;
                got++;
            end else if (got > 0) begin
                bubble = 1'b1;
            end
            prev_pending = o_imem_req && !i_imem_ack;
            prev_addr    = o_imem_addr;
        end
        checks++; if (got != 6) begin errors++; $display("FAIL wait_timeout: got %0d instructions expected 6", got); end
        checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL wait_bubble: got %b expected 1", bubble); end
        wait_cycles = 0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (5) @(negedge clk);
        checks++; if (o_imem_req !== 1'b1 || o_ir_valid !== 1'b1 || o_pc !== 32'h6) begin errors++; $display("FAIL mrst_setup: got req=%b v=%b pc=%h expected req=1 v=1 pc=6", o_imem_req, o_ir_valid, o_pc); end
        ack_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (o_imem_req !== 1'b0 || o_ir_valid !== 1'b0) begin errors++; $display("FAIL mrst_idle: got req=%b v=%b expected req=0 v=0", o_imem_req, o_ir_valid); end
        checks++; if (o_pc !== 32'h0 || o_imem_addr !== 32'h0) begin errors++; $display("FAIL mrst_pc: got pc=%h addr=%h expected pc=0 addr=0", o_pc, o_imem_addr); end
        rst = 1'b0; ack_en = 1'b1;
        @(negedge clk);
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin errors++; $display("FAIL mrst_req: got req=%b addr=%h expected req=1 addr=0", o_imem_req, o_imem_addr); end
        @(negedge clk);
        checks++; if (o_ir_valid !== 1'b1 || o_ir !== 16'hAAAA || o_pc !== 32'h0) begin errors++; $display("FAIL mrst_first: got v=%b ir=%h pc=%h expected v=1 ir=aaaa pc=0", o_ir_valid, o_ir, o_pc); end
        @(negedge clk);
        checks++; if (o_ir_valid !== 1'b1 || o_ir !== 16'hBBBB || o_pc !== 32'h2) begin errors++; $display("FAIL mrst_second: got v=%b ir=%h pc=%h expected v=1 ir=bbbb pc=2", o_ir_valid, o_ir, o_pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {16'h8000 | 16'(i * 4 + 2), 16'h8000 | 16'(i * 4)};
        mem[0]  = 32'hBBBB_AAAA;
        mem[1]  = 32'hDDDD_CCCC;
        mem[64] = 32'h2222_1111;
        rst = 1'b1; i_stall = 1'b0; i_branch = 1'b0; i_branch_target = 32'h0;

        test_reset();
        test_stall();
        test_unaligned_branch();
        test_branch_race();
        test_branch_full();
        test_wait_state();
        test_mid_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
